// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode and FSM state codes,
// plus the initial-pattern selection used when a new mode is loaded.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // Initial patterns are width-independent kinds; the top expands them to WIDTH.
  typedef enum logic [1:0] {
    INIT_ONE_HOT = 2'd0,
    INIT_ZEROS   = 2'd1,
    INIT_ONES    = 2'd2
  } init_kind_e;

  function automatic init_kind_e init_kind(mode_e m);
    init_kind_e k;
    unique case (m)
      MODE_BOUNCE: k = INIT_ONE_HOT;
      MODE_ROTATE: k = INIT_ONE_HOT;
      MODE_FILL:   k = INIT_ZEROS;
      MODE_BLINK:  k = INIT_ONES;
      default:     k = INIT_ONE_HOT;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Command port of the LED sequencer: mode/period requests over valid/ready.
interface led_seq_ctrl_if #(
  parameter int PERIOD_W = 24
);
  // A command transfers on a rising edge where cmd_valid && cmd_ready; the
  // master holds cmd_mode/cmd_period stable while cmd_valid is high and not
  // yet accepted, and cmd_ready never depends on cmd_valid.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/led_step_prescaler.sv
// Step-rate down-counter: ticks once every period_eff unpaused cycles and
// restarts from period_eff-1 whenever load is asserted.
module led_step_prescaler #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 300000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_eff_i,
  input  logic                pause_i,
  output logic                tick_o
);

  localparam logic [PERIOD_W-1:0] PERIOD_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] RESET_COUNT = PERIOD_W'(DEFAULT_PERIOD - 1);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] count_d;

  // Load wins over pause so a mode change always restarts a full interval.
  always_comb begin
    count_d = count_q;
    tick_o  = 1'b0;
    if (load_i) begin
      count_d = period_eff_i - PERIOD_ONE;
    end else if (!pause_i) begin
      if (count_q == '0) begin
        tick_o  = 1'b1;
        count_d = period_eff_i - PERIOD_ONE;
      end else begin
        count_d = count_q - PERIOD_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_COUNT;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED animation sequencer: owns the shared LED bus, steps one of four patterns
// at a programmable rate and accepts mode/period changes over a command port.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 300000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_seq_ctrl_if.slave      cmd,
  input  logic               pause,
  output logic [WIDTH-1:0]   leds,
  output logic [1:0]         mode,
  output logic               step_pulse,
  output state_e             dbg_state_o
);

  localparam logic [PERIOD_W-1:0] PERIOD_ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PERIOD_DEFAULT = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0]    LEDS_ONE_HOT   = WIDTH'(1);

  state_e              state_q;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [WIDTH-1:0]    leds_q;
  logic                dir_q;
  logic                pulse_q;

  logic                accept;
  logic                tick;
  logic [PERIOD_W-1:0] cmd_period_eff;
  logic [WIDTH-1:0]    step_leds_d;
  logic                step_dir_d;
  logic [WIDTH-1:0]    init_leds;

  assign cmd.cmd_ready  = (state_q == ST_RUN);
  assign accept         = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_period_eff = (cmd.cmd_period == '0) ? PERIOD_ONE : cmd.cmd_period;

  // period_q already holds the new period while in LOAD, so the reload uses it.
  led_step_prescaler #(
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (state_q == ST_LOAD),
    .period_eff_i (period_q),
    .pause_i      (pause),
    .tick_o       (tick)
  );

  // dir_q is the bounce direction (0 = left) or the fill phase (0 = fill).
  always_comb begin
    step_leds_d = leds_q;
    step_dir_d  = dir_q;
    unique case (mode_q)
      MODE_BOUNCE: begin
        if (!dir_q && leds_q[WIDTH-1]) begin
          step_dir_d = 1'b1;
        end else if (dir_q && leds_q[0]) begin
          step_dir_d = 1'b0;
        end
        step_leds_d = step_dir_d ? (leds_q >> 1) : (leds_q << 1);
      end
      MODE_ROTATE: begin
        step_leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
      end
      MODE_FILL: begin
        if (!dir_q && (&leds_q)) begin
          step_dir_d = 1'b1;
        end else if (dir_q && (leds_q == '0)) begin
          step_dir_d = 1'b0;
        end
        step_leds_d = {leds_q[WIDTH-2:0], ~step_dir_d};
      end
      MODE_BLINK: begin
        step_leds_d = ~leds_q;
      end
      default: begin
        step_leds_d = leds_q;
      end
    endcase
  end

  always_comb begin
    init_leds = LEDS_ONE_HOT;
    unique case (init_kind(mode_q))
      INIT_ONE_HOT: init_leds = LEDS_ONE_HOT;
      INIT_ZEROS:   init_leds = '0;
      INIT_ONES:    init_leds = '1;
      default:      init_leds = LEDS_ONE_HOT;
    endcase
  end

  // A step and a command accept may share an edge: the step lands first and
  // the LOAD cycle overwrites the pattern on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_BOUNCE;
      period_q <= PERIOD_DEFAULT;
      leds_q   <= LEDS_ONE_HOT;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          pulse_q <= tick;
          if (tick) begin
            leds_q <= step_leds_d;
            dir_q  <= step_dir_d;
          end
          if (accept) begin
            mode_q   <= mode_e'(cmd.cmd_mode);
            period_q <= cmd_period_eff;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          leds_q  <= init_leds;
          dir_q   <= 1'b0;
          pulse_q <= 1'b0;
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign leds        = leds_q;
  assign mode        = mode_q;
  assign step_pulse  = pulse_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random traffic, checked each
// cycle against a step-index/closed-form pattern model.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  localparam int W   = 16;
  localparam int PW  = 24;
  localparam int DEF = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pause;
  logic [W-1:0] leds;
  logic [1:0]   mode;
  logic         step_pulse;
  state_e       dbg_state;

  led_seq_ctrl_if #(.PERIOD_W(PW)) cmd_if ();

  led_seq_ctrl #(
    .WIDTH          (W),
    .PERIOD_W       (PW),
    .DEFAULT_PERIOD (DEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .pause       (pause),
    .leds        (leds),
    .mode        (mode),
    .step_pulse  (step_pulse),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // m_k     : steps taken since the current pattern was loaded
  // m_wait  : unpaused RUN edges remaining until the next step
  // m_mode  : latched mode (visible on `mode`); m_pmode: mode of the shown pattern
  int         m_k;
  int         m_wait;
  int         m_period;
  logic [1:0] m_mode;
  logic [1:0] m_pmode;
  bit         m_load;
  bit         m_pulse;

  function automatic logic [W-1:0] pattern(logic [1:0] md, int k);
    logic [W-1:0] one;
    logic [W-1:0] ones;
    int pos;
    int j;
    one  = 1;
    ones = '1;
    case (md)
      2'd0: begin
        pos = k % (2 * W - 2);
        if (pos >= W) pos = 2 * W - 2 - pos;
        return one << pos;
      end
      2'd1: return one << (k % W);
      2'd2: begin
        j = k % (2 * W);
        if (j <= W) return ~(ones << j);
        return ones << (j - W);
      end
      default: return (k % 2 == 0) ? ones : '0;
    endcase
  endfunction

  task automatic model_reset();
    m_k      = 0;
    m_mode   = 2'd0;
    m_pmode  = 2'd0;
    m_period = DEF;
    m_wait   = DEF;
    m_load   = 0;
    m_pulse  = 0;
  endtask

  task automatic model_edge();
    if (m_load) begin
      m_load  = 0;
      m_k     = 0;
      m_pmode = m_mode;
      m_wait  = m_period;
      m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (!pause) begin
        m_wait--;
        if (m_wait == 0) begin
          m_k++;
          m_pulse = 1;
          m_wait  = m_period;
        end
      end
      if (cmd_if.cmd_valid) begin
        m_mode   = cmd_if.cmd_mode;
        m_period = (cmd_if.cmd_period == '0) ? 1 : int'(cmd_if.cmd_period);
        m_load   = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("leds", 32'(leds), 32'(pattern(m_pmode, m_k)));
    chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_load));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(logic [1:0] md, int period);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_mode   = md;
    cmd_if.cmd_period = PW'(period);
    cycle();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n             = 1'b0;
    pause             = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_mode   = 2'd0;
    cmd_if.cmd_period = '0;
    model_reset();

    // Reset values while held in reset
    #12;
    chk("rst_leds", 32'(leds), 32'h0001);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // BOUNCE at default period 3: a full 30-step cycle and a bit more
    run(100);

    // ROTATE every 2 cycles, through the 0x8000 -> 0x0001 wrap
    send(2'd1, 2);
    chk("rotate_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    run(40);

    // FILL with period 0 (one step per cycle), full fill and drain
    send(2'd2, 0);
    run(40);

    // BLINK period 4, paused for 10 cycles mid-interval
    send(2'd3, 4);
    run(2);
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    run(12);

    // Command accepted on the same edge the prescaler expires
    send(2'd0, $urandom_range(2, 5));
    for (int i = 0; i < 20 && !(m_wait == 1 && !m_load); i++) cycle();
    send(2'd2, $urandom_range(1, 4));
    chk("coincident_pulse", 32'(step_pulse), 32'd1);
    cycle();
    chk("coincident_load", 32'(leds), 32'h0000);
    run(8);

    // Random commands, periods and pause
    for (int i = 0; i < 300; i++) begin
      cmd_if.cmd_valid  = ($urandom_range(0, 11) == 0);
      cmd_if.cmd_mode   = 2'($urandom_range(0, 3));
      cmd_if.cmd_period = PW'($urandom_range(0, 5));
      pause             = ($urandom_range(0, 5) == 0);
      cycle();
    end
    cmd_if.cmd_valid = 1'b0;
    pause            = 1'b0;
    run(4);

    // Async reset pulse during FILL drain
    send(2'd2, 1);
    run(22);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0001);
    chk("async_rst_mode", 32'(mode), 32'd0);
    chk("async_rst_pulse", 32'(step_pulse), 32'd0);
    chk("async_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run(12);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
